placa_emisor: RTL and testbench
===============================

# placa_emisor

Keypad-stream generator for the parking plate path: takes a complete 24-bit plate (six 4-bit digits) and replays it as the `ingplaca`/`teclado` stream that the plate-entry block consumes. Used for auto-entry of stored plates and as the stimulus source for the entry path. It emits one digit per single-cycle pulse separated by zero gaps, because the entry block captures every cycle on which `teclado` is nonzero. It holds `ingplaca` high long enough for the receiver to assemble the full plate.

## Interface
- GAP, 2: zero cycles on `teclado` before the first digit and after every digit except the last; legal range ≥1.
- HOLD, 4: cycles `ingplaca` stays high after the last digit; legal range ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to send `placa_in`; sampled only in IDLE.
- placa_in  in  24  plate to send; digit 1 = [23:20] … digit 6 = [3:0]; captured on the accepted `start` edge.
- abort  in  1  cancel the transfer in progress.
- ingplaca  out  1  plate-entry enable toward the receiver; registered.
- teclado  out  4  digit bus; 0 = no key; registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when `start` is rejected.

## Operation
- FSM states: IDLE, LEAD, SEND, GAP, HOLD.
- IDLE:
  - `start`=1 and every nibble of `placa_in` nonzero: latch the plate, digit index := 1, counter := GAP, go to LEAD.
  - `start`=1 and any nibble zero: pulse `err`, stay in IDLE. Zero is "no key" on the bus and cannot be sent.
- LEAD: `ingplaca`=1, `teclado`=0 for GAP cycles, then go to SEND.
- SEND: `ingplaca`=1, `teclado`=latched digit[index] for exactly one cycle.
  - index<6: go to GAP.
  - index=6: go to HOLD.
- GAP: `teclado`=0 for GAP cycles, index+1, then go to SEND.
- HOLD: `ingplaca`=1, `teclado`=0 for HOLD cycles. Then go to IDLE with `done`=1 for one cycle, `ingplaca`=0.
- Dropping `ingplaca` at the end of HOLD clears the receiver. This is intended: the consumer samples the assembled plate during HOLD.
- `abort`=1 in any non-IDLE state: next cycle is IDLE with `ingplaca`=0, `teclado`=0, no `done`. `abort` has priority over every other transition.
- `start` while busy is ignored, not queued. `start` and `abort` together in IDLE: `start` is evaluated and `abort` is ignored.
- The latched plate cannot change mid-transfer; `placa_in` is don't-care after capture.
- Counter width is clog2(max(GAP,HOLD)+1). Digit index is 3 bits, range 1..6.

## Timing
- Reset values: `ingplaca`=0, `teclado`=0, `busy`=0, `done`=0, `err`=0, state IDLE, latched plate 0.
- Reset asserted mid-transfer forces these values immediately, without waiting for a clock edge.
- Cycle numbering: accepted `start` edge = edge 0; "cycle n" = outputs after edge n.
- Cycles 1..GAP: LEAD, `ingplaca`=1, `busy`=1.
- Digit k appears in cycle k·(GAP+1), for one cycle only.
- Last digit in cycle 6·(GAP+1). HOLD occupies the next HOLD cycles.
- `done`=1, `busy`=0, `ingplaca`=0 in cycle 6·(GAP+1)+HOLD+1. With defaults that is digits in cycles 3,6,9,12,15,18, HOLD 19–22, `done` in 23.
- `err` appears in cycle 1 after a rejected `start`; `busy` stays 0.
- A new `start` is accepted in the same cycle that `done` is high.
- Gaps guarantee two identical consecutive digits, e.g. 7,7, are captured as two digits.

## Test plan
- Reset, then `start` with `placa_in`=0x123456 (defaults) -> `teclado` = 1,2,3,4,5,6 in cycles 3,6,…,18, 0 elsewhere. `ingplaca`=1 in cycles 1–22. `done` in cycle 23. A connected plate-entry block shows placa=0x123456 during HOLD.
- `placa_in`=0x777777 -> six separate one-cycle 7 pulses; the receiver assembles 0x777777, with no duplicate or missed digits.
- `placa_in`=0x120456 -> `err`=1 in cycle 1; `ingplaca`, `busy` and `teclado` stay 0.
- `abort` pulsed in cycle 10 -> cycle 11: `ingplaca`=0, `teclado`=0, `busy`=0; no `done`, no further digits.
- `rst_n` low asynchronously in cycle 7 -> all outputs 0 before the next edge. After release, a new `start` with 0x987654 sends correctly from digit 1.
- `start` re-asserted in cycles 5–20 with a different plate -> ignored, the original plate is sent. `start` in the `done` cycle -> accepted, and the next transfer begins with LEAD.

Source files
------------

// File: rtl/placa_emisor_if.sv
// Handshake and keypad-bus bundle between a plate source and placa_emisor.
interface placa_emisor_if;
    logic        start;
    logic [23:0] placa_in;
    logic        abort;
    logic        ingplaca;
    logic [3:0]  teclado;
    logic        busy;
    logic        done;
    logic        err;

    // Requester side: issues plates, observes the generated stream.
    modport master (
        output start,
        output placa_in,
        output abort,
        input  ingplaca,
        input  teclado,
        input  busy,
        input  done,
        input  err
    );

    // Generator side.
    modport slave (
        input  start,
        input  placa_in,
        input  abort,
        output ingplaca,
        output teclado,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/placa_emisor.sv
// Replays a stored 24-bit plate as an ingplaca/teclado keypad stream: each digit
// is a one-cycle pulse separated by zero cycles, so the receiver sees repeated
// digits as distinct keys. ingplaca is held through a trailing window so the
// receiver can present the assembled plate before it is cleared.
module placa_emisor #(
    parameter int unsigned GAP  = 2,
    parameter int unsigned HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    placa_emisor_if.slave bus
);

    localparam int unsigned MaxCnt = (GAP > HOLD) ? GAP : HOLD;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StSend,
        StGap,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [23:0]     plate_q, plate_d;
    logic            ingplaca_q, ingplaca_d;
    logic [3:0]      teclado_q, teclado_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            plate_ok;
    logic [3:0]      digit_sel;

    // Zero means "no key" on the bus, so a plate with a zero digit cannot be sent.
    assign plate_ok = (bus.placa_in[23:20] != 4'h0) && (bus.placa_in[19:16] != 4'h0) &&
                      (bus.placa_in[15:12] != 4'h0) && (bus.placa_in[11:8]  != 4'h0) &&
                      (bus.placa_in[7:4]   != 4'h0) && (bus.placa_in[3:0]   != 4'h0);

    // Next state, counters and plate capture; abort outranks every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        plate_d = plate_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if ((state_q != StIdle) && bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (plate_ok) begin
                            plate_d = bus.placa_in;
                            idx_d   = 3'd1;
                            cnt_d   = CntW'(GAP);
                            state_d = StLead;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StLead: begin
                    if (cnt_q == CntW'(1)) begin
                        state_d = StSend;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StSend: begin
                    if (idx_q == 3'd6) begin
                        cnt_d   = CntW'(HOLD);
                        state_d = StHold;
                    end else begin
                        cnt_d   = CntW'(GAP);
                        state_d = StGap;
                    end
                end
                StGap: begin
                    if (cnt_q == CntW'(1)) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == CntW'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Digit 1 is the most significant nibble.
    always_comb begin
        digit_sel = 4'h0;
        case (idx_d)
            3'd1:    digit_sel = plate_q[23:20];
            3'd2:    digit_sel = plate_q[19:16];
            3'd3:    digit_sel = plate_q[15:12];
            3'd4:    digit_sel = plate_q[11:8];
            3'd5:    digit_sel = plate_q[7:4];
            3'd6:    digit_sel = plate_q[3:0];
            default: digit_sel = 4'h0;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ingplaca_d = (state_d != StIdle);
        teclado_d  = (state_d == StSend) ? digit_sel : 4'h0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            plate_q    <= 24'h0;
            ingplaca_q <= 1'b0;
            teclado_q  <= 4'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            plate_q    <= plate_d;
            ingplaca_q <= ingplaca_d;
            teclado_q  <= teclado_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.ingplaca = ingplaca_q;
    assign bus.teclado  = teclado_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_placa_emisor.sv
// Bench for placa_emisor: expected digits go into a scoreboard queue when a plate
// is issued and are popped as pulses appear on teclado; per-cycle waveform
// expectations come from the cycle formulas of the stream.
module tb_placa_emisor;

    localparam int unsigned GAP    = 2;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned LAST   = 6 * (GAP + 1);
    localparam int unsigned DONE_C = LAST + HOLD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    placa_emisor_if bus ();

    placa_emisor #(
        .GAP  (GAP),
        .HOLD (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3:0]  exp_q[$];
    logic [23:0] rx_placa;

    // Plate-entry receiver: shifts in every nonzero key while ingplaca is high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_placa <= 24'h0;
        end else if (!bus.ingplaca) begin
            rx_placa <= 24'h0;
        end else if (bus.teclado != 4'h0) begin
            rx_placa <= {rx_placa[19:0], bus.teclado};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] digit_of(input logic [23:0] p, input int k);
        return p[4*(6-k) +: 4];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ingplaca"}, bus.ingplaca, 1'b0);
        check({tag, "_teclado"}, bus.teclado, 4'h0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
    endtask

    // Issue one plate and follow it cycle by cycle. Returns in the done cycle
    // (or equivalent idle cycle) without advancing, so a following call
    // drives start in that cycle.
    task automatic send(input logic [23:0] plate, input int abort_at, input int rst_at,
                        input bit restart, input bit abort_start);
        bit         stopped;
        logic       exp_ing;
        logic [3:0] exp_t;
        logic       exp_done;
        stopped      = 1'b0;
        bus.start    = 1'b1;
        bus.placa_in = plate;
        bus.abort    = abort_start;
        for (int k = 1; k <= 6; k++) exp_q.push_back(digit_of(plate, k));
        tick();
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.placa_in = 24'h0;
        for (int c = 1; c <= DONE_C; c++) begin
            if (abort_at != 0 && c == abort_at + 1) begin
                stopped = 1'b1;
                exp_q.delete();
            end
            exp_ing  = !stopped && (c <= LAST + HOLD);
            exp_t    = (!stopped && (c % (GAP + 1) == 0) && (c <= LAST)) ?
                       digit_of(plate, c / (GAP + 1)) : 4'h0;
            exp_done = !stopped && (c == DONE_C);
            check("ingplaca", bus.ingplaca, exp_ing);
            check("teclado", bus.teclado, exp_t);
            check("busy", bus.busy, exp_ing);
            check("done", bus.done, exp_done);
            check("err", bus.err, 1'b0);
            if (bus.teclado != 4'h0) begin
                if (exp_q.size() == 0) check("extra_digit", bus.teclado, 4'h0);
                else check("sb_digit", bus.teclado, exp_q.pop_front());
            end
            if (!stopped && c > LAST && c <= LAST + HOLD) check("rx_placa", rx_placa, plate);
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_idle("async_rst");
                exp_q.delete();
                @(posedge clk);
                #1 rst_n = 1'b1;
                tick();
                return;
            end
            if (c < DONE_C) begin
                bus.abort = (c == abort_at);
                if (restart && c >= 5 && c <= 20) begin
                    bus.start    = 1'b1;
                    bus.placa_in = 24'hABCDEF;
                end else begin
                    bus.start    = 1'b0;
                    bus.placa_in = 24'h0;
                end
                tick();
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic reject(input logic [23:0] plate);
        bus.start    = 1'b1;
        bus.placa_in = plate;
        tick();
        bus.start    = 1'b0;
        check("rej_err", bus.err, 1'b1);
        check("rej_busy", bus.busy, 1'b0);
        check("rej_ingplaca", bus.ingplaca, 1'b0);
        check("rej_teclado", bus.teclado, 4'h0);
        tick();
        check("rej_err_pulse", bus.err, 1'b0);
        check("rej_busy2", bus.busy, 1'b0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.placa_in = 24'h0;
        #1;
        check_idle("reset");
        repeat (2) tick();
        check_idle("reset_clk");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        send(24'h123456, 0, 0, 1'b0, 1'b0);
        // start in the done cycle; restarts while busy must be ignored
        send(24'h777777, 0, 0, 1'b1, 1'b0);
        reject(24'h120456);
        send(24'h123456, 10, 0, 1'b0, 1'b0);
        tick();
        send(24'h123456, 0, 7, 1'b0, 1'b0);
        check_idle("after_rst");
        // start wins over abort in idle
        send(24'h987654, 0, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
